// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register indices, FSM states, ID width.
package irq_ctrl_pkg;

  localparam int unsigned ID_W = 5;

  localparam logic [3:0] REG_PENDING  = 4'd0;
  localparam logic [3:0] REG_ENABLE   = 4'd1;
  localparam logic [3:0] REG_CLAIM    = 4'd2;
  localparam logic [3:0] REG_COMPLETE = 4'd3;
  localparam logic [3:0] REG_STATUS   = 4'd4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  function automatic logic [31:0] status_word(input logic busy, input logic [ID_W-1:0] id);
    return {19'b0, id, 7'b0, busy};
  endfunction

endpackage

// File: rtl/irq_ctrl_prio_enc.sv
// Lowest-index priority encoder: returns (index + 1) of the lowest set bit, 0 when empty.
module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned NSRC = 8
) (
  input  logic [NSRC-1:0] req,
  output logic [ID_W-1:0] id
);

  // Scan downward so the last hit, i.e. the lowest index, wins.
  always_comb begin
    id = '0;
    for (int unsigned i = NSRC; i > 0; i--) begin
      if (req[i-1]) id = ID_W'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Edge-capturing interrupt controller with claim/complete handshake.
// Define IRQ_CTRL_SYNC_EN to put a two-flop synchronizer in front of edge detection.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned NSRC = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      a,
  input  logic [31:0]     d,
  input  logic            we,
  input  logic            rd,
  output logic [31:0]     spo,
  input  logic [NSRC-1:0] src,
  output logic            irq_out
);

  state_e          state_q, state_d;
  logic [NSRC-1:0] samp_q, samp_d;
  logic [NSRC-1:0] hist_q, hist_d;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] enable_q, enable_d;
  logic [ID_W-1:0] in_service_q, in_service_d;
  logic            irq_out_q, irq_out_d;

  logic [NSRC-1:0] ready;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] claim_mask;
  logic [ID_W-1:0] claim_id;
  logic            claim_go;
  logic            complete_go;
  logic            unused_d;

`ifdef IRQ_CTRL_SYNC_EN
  logic [NSRC-1:0] sync1_q, sync1_d;
  logic [NSRC-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = src;
    sync2_d = sync1_q;
    samp_d  = sync2_q;
  end

  always_ff @(posedge clk) begin
    sync1_q <= sync1_d;
    sync2_q <= sync2_d;
  end
`else
  always_comb samp_d = src;
`endif

  assign ready   = pending_q & enable_q;
  assign rise    = samp_q & ~hist_q;
  assign irq_out = irq_out_q;

  irq_prio_enc #(.NSRC(NSRC)) u_prio (
    .req (ready),
    .id  (claim_id)
  );

  always_comb begin
    claim_mask = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      claim_mask[i] = (claim_id == ID_W'(i + 1));
    end
  end

  assign claim_go    = rd && (a == REG_CLAIM) && (state_q == ST_IDLE) && (claim_id != '0);
  assign complete_go = we && (a == REG_COMPLETE) && (state_q == ST_BUSY) &&
                       (d[ID_W-1:0] == in_service_q);

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    enable_d     = enable_q;
    in_service_d = in_service_q;
    hist_d       = samp_q;
    irq_out_d    = (state_q == ST_IDLE) && (|ready);

    case (state_q)
      ST_IDLE: begin
        if (claim_go) begin
          pending_d    = pending_q & ~claim_mask;
          in_service_d = claim_id;
          state_d      = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (complete_go) begin
          in_service_d = '0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A fresh edge overrides a same-cycle claim clear of that bit.
    pending_d = pending_d | rise;

    if (we && (a == REG_ENABLE)) enable_d = d[NSRC-1:0];

    // History follows the value being sampled now so a level held through reset is not an edge.
    if (rst) begin
      state_d      = ST_IDLE;
      pending_d    = '0;
      enable_d     = '0;
      in_service_d = '0;
      hist_d       = samp_d;
      irq_out_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    state_q      <= state_d;
    samp_q       <= samp_d;
    hist_q       <= hist_d;
    pending_q    <= pending_d;
    enable_q     <= enable_d;
    in_service_q <= in_service_d;
    irq_out_q    <= irq_out_d;
  end

  always_comb begin
    spo = '0;
    case (a)
      REG_PENDING: spo = 32'(pending_q);
      REG_ENABLE:  spo = 32'(enable_q);
      REG_CLAIM:   spo = 32'(claim_id);
      REG_STATUS:  spo = status_word(state_q == ST_BUSY, in_service_q);
      default:     spo = '0;
    endcase
  end

  assign unused_d = ^d;

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter NSRC, default 8, number of interrupt sources (1..31).
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 a  input  4  word register index on the peripheral bus.
REQ-005 d  input  32  write data.
REQ-006 we  input  1  write strobe; one write per cycle.
REQ-007 rd  input  1  read strobe; qualifies read side effects only.
REQ-008 spo  output  32  combinational read data for index a.
REQ-009 src  input  NSRC  peripheral interrupt lines, e.g. the gpio irq pulse.
REQ-010 irq_out  output  1  registered interrupt request to the CPU.

Function
REQ-011 Register map: 0 PENDING (read-only), 1 ENABLE (read/write, bits NSRC-1:0), 2 CLAIM (read), 3 COMPLETE (write), 4 STATUS (read: bit0 busy, bits 12:8 in-service ID); all other indices read 0 and ignore writes.
REQ-012 Source capture is edge-triggered: a 0->1 transition of the sampled src[i] sets pending[i] on the next clock.
REQ-013 Controller FSM has two states, IDLE and BUSY; reset enters IDLE.
REQ-014 Claim ID is (lowest index i with pending[i] & enable[i]) + 1, or 0 if no such i; spo at a=2 returns this ID combinationally.
REQ-015 In IDLE, rd with a=2 and nonzero claim ID clears that pending bit, stores the ID as in-service, and moves to BUSY on the same edge.
REQ-016 rd with a=2 in BUSY, or with claim ID 0, returns the current claim ID and changes no state.
REQ-017 In BUSY, we with a=3 and d[4:0] equal to the in-service ID returns to IDLE and clears in-service to 0; a mismatched ID is ignored.
REQ-018 irq_out is 1 exactly when the state is IDLE and (pending & enable) is nonzero, as a registered function of the previous cycle's state.
REQ-019 Latency without sync: src edge sampled at cycle N gives pending at N+1 and irq_out at N+2.
REQ-020 If a capture edge and a claim of the same source occur in one cycle, the pending bit ends set.
REQ-021 Edges on the in-service source while BUSY set pending; that source is serviced again after COMPLETE.
REQ-022 Clearing an enable bit keeps its pending bit; the source is neither signalled nor claimable until re-enabled.
REQ-023 Repeated edges before a claim collapse into one pending bit; no counting.

Reset
REQ-024 Reset sets pending=0, enable=0, in-service=0, state=IDLE, irq_out=0, and sets the edge-detect history to the current sampled src, so a source held high at reset produces no edge.
REQ-025 Reset asserted while BUSY abandons the in-service interrupt; a later COMPLETE for that ID is ignored.

Configuration
REQ-026 With IRQ_CTRL_SYNC_EN defined, each src bit passes through a two-flop synchronizer before edge detection, adding 2 cycles to REQ-019 latencies (irq_out at N+4).
REQ-027 Without IRQ_CTRL_SYNC_EN, src is registered once; sources must be synchronous to clk.

Structure
REQ-028 A shared package holds the register index constants (PENDING, ENABLE, CLAIM, COMPLETE, STATUS), the FSM state encoding, and the ID width of 5.
REQ-029 The lowest-index priority selection sits in one sub-module, irq_prio_enc (NSRC-bit vector in, ID out, zero when empty).

Verification
REQ-030 Enable=0x05, pulse src[2] for 1 cycle -> irq_out=1 two cycles later; claim returns 3; irq_out=0; COMPLETE 3 -> IDLE.
REQ-031 Pulse src[0] and src[2] together, enable=0x05 -> first claim 1, COMPLETE 1, second claim 3, COMPLETE 3, irq_out=0.
REQ-032 BUSY on ID 1, pulse src[0] again -> irq_out held 0; COMPLETE 2 ignored (STATUS busy=1); COMPLETE 1 -> irq_out=1 next cycle.
REQ-033 src[3] edge in the claim cycle of ID 4 -> PENDING bit3=1 after the claim; STATUS in-service=4.
REQ-034 Enable=0, pulse src[1] -> PENDING=0x02, irq_out=0, claim reads 0; enable=0x02 -> irq_out=1 the cycle after the write.
REQ-035 src[5] held high through rst -> no pending after reset; rst during BUSY -> STATUS=0, irq_out=0.
